// File: rtl/split_pkg.sv
// split_pkg: shared slot-state type, counter widths and the saturating
// increment used by split_n and split_slot.
package split_pkg;

    // Occupancy of a one-entry output holding slot.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int unsigned DROP_CNT_W = 8;
    localparam int unsigned PKT_CNT_W  = 16;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [PKT_CNT_W-1:0] sat_inc(
        input logic [PKT_CNT_W-1:0] value,
        input logic [PKT_CNT_W-1:0] max_val
    );
        return (value >= max_val) ? value : value + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/split_slot.sv
// split_slot: one-entry holding register for a single output channel.
// A load always wins over a drain, so drain+reload keeps the slot FULL.
module split_slot
    import split_pkg::*;
#(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    slot_state_e      r_state;
    slot_state_e      w_state_next;
    logic [WIDTH-1:0] r_data;
    logic             w_drain;

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Data register only changes on a load, so it is stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    // Next-state: load fills, drain without load empties.
    always_comb begin
        w_drain      = (r_state == FULL) && i_ready;
        w_state_next = r_state;
        if (i_load) begin
            w_state_next = FULL;
        end else if (w_drain) begin
            w_state_next = EMPTY;
        end
    end

    assign o_valid = (r_state == FULL);
    assign o_data  = r_data;

endmodule

// File: rtl/split_n.sv
// split_n: routes each (control, data) token pair to one of NOUT output
// slots selected by the control token; out-of-range selects are dropped
// and counted. Optional per-output transfer counters are built when the
// macro SPLIT_N_STATS_EN is defined (adds the pkt_cnt port).
module split_n
    import split_pkg::*;
#(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned NOUT  = 4,
    parameter int unsigned SELW  = $clog2(NOUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    ctl_valid,
    output logic                    ctl_ready,
    input  logic [SELW-1:0]         ctl_data,
    output logic [NOUT-1:0]         out_valid,
    input  logic [NOUT-1:0]         out_ready,
    output logic [NOUT*WIDTH-1:0]   out_data,
    output logic [DROP_CNT_W-1:0]   drop_cnt
`ifdef SPLIT_N_STATS_EN
    ,
    output logic [NOUT*PKT_CNT_W-1:0] pkt_cnt
`endif
);

    logic                  w_in_range;
    logic                  w_dest_free;
    logic                  w_accept;
    logic [NOUT-1:0]       w_load;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // Decode the select: is it a real output, and can that slot take a token now.
    always_comb begin
        w_in_range  = 1'b0;
        w_dest_free = 1'b0;
        for (int k = 0; k < NOUT; k++) begin
            if (ctl_data == SELW'(k)) begin
                w_in_range  = 1'b1;
                w_dest_free = !out_valid[k] || out_ready[k];
            end
        end
    end

    // Both tokens are consumed together; rst_n gating keeps ready low in reset.
    assign w_accept  = rst_n && in_valid && ctl_valid && (!w_in_range || w_dest_free);
    assign in_ready  = w_accept;
    assign ctl_ready = w_accept;

    // One-hot load strobe for the addressed slot.
    always_comb begin
        w_load = '0;
        for (int k = 0; k < NOUT; k++) begin
            w_load[k] = w_accept && (ctl_data == SELW'(k));
        end
    end

    for (genvar k = 0; k < NOUT; k++) begin : g_slot
        split_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[k]),
            .i_data  (in_data),
            .i_ready (out_ready[k]),
            .o_valid (out_valid[k]),
            .o_data  (out_data[k*WIDTH +: WIDTH])
        );
    end

    // Saturating count of pairs whose select names no output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_in_range) begin
            r_drop_cnt <= DROP_CNT_W'(sat_inc(PKT_CNT_W'(r_drop_cnt),
                                              PKT_CNT_W'({DROP_CNT_W{1'b1}})));
        end
    end

    assign drop_cnt = r_drop_cnt;

`ifdef SPLIT_N_STATS_EN
    logic [NOUT-1:0][PKT_CNT_W-1:0] r_pkt_cnt;

    // Saturating per-output count of completed output transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt <= '0;
        end else begin
            for (int k = 0; k < NOUT; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    r_pkt_cnt[k] <= sat_inc(r_pkt_cnt[k], '1);
                end
            end
        end
    end

    assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_split_n.sv
// tb_split_n: directed self-checking bench for split_n. Instance a uses the
// default NOUT=4; instance b uses NOUT=3 to exercise out-of-range drops.
module tb_split_n;

    localparam int unsigned W = 11;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic           a_in_valid, a_in_ready, a_ctl_valid, a_ctl_ready;
    logic [W-1:0]   a_in_data;
    logic [1:0]     a_ctl_data;
    logic [3:0]     a_out_valid, a_out_ready;
    logic [4*W-1:0] a_out_data;
    logic [7:0]     a_drop_cnt;

    logic           b_in_valid, b_in_ready, b_ctl_valid, b_ctl_ready;
    logic [W-1:0]   b_in_data;
    logic [1:0]     b_ctl_data;
    logic [2:0]     b_out_valid, b_out_ready;
    logic [3*W-1:0] b_out_data;
    logic [7:0]     b_drop_cnt;

`ifdef SPLIT_N_STATS_EN
    logic [4*16-1:0] a_pkt_cnt;
    logic [3*16-1:0] b_pkt_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    split_n #(
        .WIDTH (W),
        .NOUT  (4)
    ) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .ctl_valid (a_ctl_valid),
        .ctl_ready (a_ctl_ready),
        .ctl_data  (a_ctl_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .drop_cnt  (a_drop_cnt)
`ifdef SPLIT_N_STATS_EN
        ,
        .pkt_cnt   (a_pkt_cnt)
`endif
    );

    split_n #(
        .WIDTH (W),
        .NOUT  (3)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .ctl_valid (b_ctl_valid),
        .ctl_ready (b_ctl_ready),
        .ctl_data  (b_ctl_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .drop_cnt  (b_drop_cnt)
`ifdef SPLIT_N_STATS_EN
        ,
        .pkt_cnt   (b_pkt_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] sel, input logic [W-1:0] d);
        a_in_valid  = v;
        a_ctl_valid = v;
        a_ctl_data  = sel;
        a_in_data   = d;
    endtask

    function automatic logic [W-1:0] a_slot(input int k);
        return a_out_data[k*W +: W];
    endfunction

    function automatic logic [W-1:0] b_slot(input int k);
        return b_out_data[k*W +: W];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with valids already asserted.
        rst_n       = 1'b0;
        drive_a(1'b1, 2'd2, 11'h5A5);
        a_out_ready = 4'hF;
        b_in_valid  = 1'b0;
        b_ctl_valid = 1'b0;
        b_ctl_data  = 2'd0;
        b_in_data   = '0;
        b_out_ready = 3'b111;
        #2;
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_ctl_ready", a_ctl_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_drop", a_drop_cnt, 0);
        chk("rst_b_out_valid", b_out_valid, 0);

        // Route to output 2, visible one cycle after the first edge.
        #1 rst_n = 1'b1;
        #1;
        chk("r030_in_ready", a_in_ready, 1);
        chk("r030_ctl_ready", a_ctl_ready, 1);
        tick();
        chk("r030_valid", a_out_valid, 4'b0100);
        chk("r030_data", a_slot(2), 11'h5A5);
        drive_a(1'b0, 2'd0, '0);
        tick();
        chk("r030_drain", a_out_valid, 0);

        // Stalled output 1 holds, blocks its own traffic, not output 3.
        a_out_ready = 4'b1101;
        drive_a(1'b1, 2'd1, 11'h001);
        #1 chk("r031_acc1", a_in_ready, 1);
        tick();
        chk("r031_v1", a_out_valid, 4'b0010);
        chk("r031_d1", a_slot(1), 11'h001);
        drive_a(1'b1, 2'd1, 11'h002);
        #1;
        chk("r031_stall", a_in_ready, 0);
        chk("r031_stall_ctl", a_ctl_ready, 0);
        tick();
        chk("r031_hold_v", a_out_valid, 4'b0010);
        chk("r031_hold_d", a_slot(1), 11'h001);
        drive_a(1'b1, 2'd3, 11'h7FF);
        #1 chk("r031_bypass", a_in_ready, 1);
        tick();
        chk("r031_v3", a_out_valid, 4'b1010);
        chk("r031_d3", a_slot(3), 11'h7FF);
        chk("r031_d1_still", a_slot(1), 11'h001);
        a_out_ready = 4'hF;
        drive_a(1'b1, 2'd1, 11'h002);
        #1 chk("r031_reload_ready", a_in_ready, 1);
        tick();
        chk("r031_reload_v", a_out_valid, 4'b0010);
        chk("r031_reload_d", a_slot(1), 11'h002);
        drive_a(1'b0, 2'd0, '0);
        tick();
        chk("r031_empty", a_out_valid, 0);

        // Data without control never accepts; control alone neither.
        a_in_valid  = 1'b1;
        a_ctl_valid = 1'b0;
        a_ctl_data  = 2'd0;
        a_in_data   = 11'h055;
        for (int i = 0; i < 5; i++) begin
            #1 chk("r033_no_ctl", a_in_ready, 0);
            tick();
        end
        chk("r033_no_out", a_out_valid, 0);
        a_ctl_valid = 1'b1;
        #1 chk("r033_acc", a_in_ready, 1);
        tick();
        drive_a(1'b0, 2'd0, '0);
        chk("r033_v", a_out_valid, 4'b0001);
        chk("r033_d", a_slot(0), 11'h055);
        tick();
        chk("r033_single", a_out_valid, 0);
        a_ctl_valid = 1'b1;
        #1 chk("r014_ctl_only", a_in_ready, 0);
        drive_a(1'b0, 2'd0, '0);
        chk("a_no_drops", a_drop_cnt, 0);

        // Asynchronous reset clears a full slot before any edge.
        a_out_ready = 4'b1011;
        drive_a(1'b1, 2'd2, 11'h3C3);
        tick();
        drive_a(1'b0, 2'd0, '0);
        chk("r035_full", a_out_valid, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("r035_async_valid", a_out_valid, 0);
        chk("r035_async_data", a_out_data, 0);
        a_out_ready = 4'hF;
        drive_a(1'b1, 2'd2, 11'h0F0);
        tick();
        chk("r035_rst_ready", a_in_ready, 0);
        chk("r035_rst_valid", a_out_valid, 0);
        rst_n = 1'b1;
        #1 chk("r035_post_ready", a_in_ready, 1);
        tick();
        chk("r035_post_v", a_out_valid, 4'b0100);
        chk("r035_post_d", a_slot(2), 11'h0F0);
        drive_a(1'b0, 2'd0, '0);
        tick();
        chk("r035_post_drain", a_out_valid, 0);

        // 100 back-to-back tokens to output 0, one per cycle, in order.
        for (int i = 0; i < 100; i++) begin
            drive_a(1'b1, 2'd0, W'(i + 1));
            #1 chk("r034_ready", a_in_ready, 1);
            tick();
            chk("r034_valid", a_out_valid, 4'b0001);
            chk("r034_data", a_slot(0), 64'(i + 1));
        end
        drive_a(1'b0, 2'd0, '0);
        tick();
        chk("r034_done", a_out_valid, 0);
`ifdef SPLIT_N_STATS_EN
        chk("r034_pkt0", a_pkt_cnt[15:0], 100);
        chk("r034_pkt2", a_pkt_cnt[47:32], 1);
        chk("r034_pkt1", a_pkt_cnt[31:16], 0);
`endif

        // NOUT=3: in-range delivery, then select 3 drops and saturates.
        b_in_valid  = 1'b1;
        b_ctl_valid = 1'b1;
        b_ctl_data  = 2'd2;
        b_in_data   = 11'h00A;
        #1;
        chk("b_ready", b_in_ready, 1);
        chk("b_ctl_ready", b_ctl_ready, 1);
        tick();
        chk("b_v2", b_out_valid, 3'b100);
        chk("b_d2", b_slot(2), 11'h00A);
        b_ctl_data = 2'd3;
        b_in_data  = 11'h123;
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("r032_no_out", b_out_valid, 0);
            if (i == 0)   chk("r032_drop1", b_drop_cnt, 1);
            if (i == 253) chk("r032_drop254", b_drop_cnt, 254);
            if (i == 254) chk("r032_drop255", b_drop_cnt, 255);
        end
        chk("r032_ready_drop", b_in_ready, 1);
        b_in_valid  = 1'b0;
        b_ctl_valid = 1'b0;
        tick();
        chk("r032_sat", b_drop_cnt, 255);
        chk("r032_a_unaffected", a_drop_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
